// File: rtl/mem_stage.sv
// RV32I memory-access stage: load/store over a req/ack data port, writeback
// value generation, and the MEM forwarding pair / stall line back to execute.
module mem_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IR_in,
  input  logic [31:0]       ALU_in,
  input  logic [31:0]       B_in,
  input  logic [31:0]       PC_in,
  input  logic              v_in,
  output logic              r_out,
  output logic              v_out,
  input  logic              r_in,
  output logic [31:0]       IR_out,
  output logic [31:0]       WD_out,
  output logic [31:0]       FM,
  output logic [4:0]        AM,
  output logic              stall,
  output logic              mis_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, HOLD} state_t;

  state_t            state_q, state_d;
  logic              v_q, v_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       wd_q, wd_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mis_err_q, mis_err_d;
  logic              bub_q, bub_d;
  logic [1:0]        off_q, off_d;

  logic [6:0]  op_in;
  logic [2:0]  f3_in;
  logic [1:0]  off_in;
  logic        is_load_in, is_store_in, misalign_in, accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [6:0]  op_q;
  logic [4:0]  rd_q;

  assign op_in       = IR_in[6:0];
  assign f3_in       = IR_in[14:12];
  assign off_in      = ALU_in[1:0];
  assign is_load_in  = (op_in == OP_LOAD);
  assign is_store_in = (op_in == OP_STORE);
  assign misalign_in = ((f3_in == 3'b010) && (off_in != 2'b00)) ||
                       (((f3_in == 3'b001) || (f3_in == 3'b101)) && off_in[0]);

  assign r_out  = (state_q == IDLE) && (!v_q || r_in);
  assign accept = v_in && r_out;

  always_comb begin
    st_be    = '0;
    st_wdata = B_in;
    case (f3_in)
      3'b000: begin
        st_be    = 4'b0001 << off_in;
        st_wdata = {4{B_in[7:0]}};
      end
      3'b001: begin
        st_be    = 4'b0011 << off_in;
        st_wdata = {2{B_in[15:0]}};
      end
      3'b010: st_be = 4'b1111;
      default: st_be = '0;
    endcase
  end

  // Lane selection uses the byte offset captured at accept, since dmem_addr is word-aligned.
  assign ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (ir_q[14:12])
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      3'b010:  ld_data = dmem_rdata;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    ir_d      = ir_q;
    wd_d      = wd_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mis_err_d = 1'b0;
    bub_d     = bub_q;
    off_d     = off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ir_d  = IR_in;
          off_d = off_in;
          bub_d = 1'b0;
          if ((is_load_in || is_store_in) && misalign_in) begin
            v_d       = 1'b1;
            wd_d      = '0;
            bub_d     = 1'b1;
            mis_err_d = 1'b1;
          end else if (is_load_in || is_store_in) begin
            state_d = MEM_WAIT;
            v_d     = 1'b0;
            req_d   = 1'b1;
            we_d    = is_store_in;
            addr_d  = {ALU_in[ADDR_W-1:2], 2'b00};
            be_d    = is_store_in ? st_be : 4'b1111;
            wdata_d = is_store_in ? st_wdata : '0;
          end else begin
            v_d  = 1'b1;
            wd_d = ((op_in == OP_JAL) || (op_in == OP_JALR)) ? PC_in + 32'd4 : ALU_in;
          end
        end else if (v_q && r_in) begin
          v_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          v_d     = 1'b1;
          wd_d    = (ir_q[6:0] == OP_LOAD) ? ld_data : '0;
          state_d = r_in ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (r_in) begin
          state_d = IDLE;
          v_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      v_q       <= 1'b0;
      ir_q      <= '0;
      wd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      mis_err_q <= 1'b0;
      bub_q     <= 1'b0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      ir_q      <= ir_d;
      wd_q      <= wd_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      mis_err_q <= mis_err_d;
      bub_q     <= bub_d;
      off_q     <= off_d;
    end
  end

  assign op_q = ir_q[6:0];
  assign rd_q = ir_q[11:7];
  assign AM   = (v_q && (op_q != OP_STORE) && (op_q != OP_BRANCH) && !bub_q) ? rd_q : 5'd0;
  assign FM   = wd_q;

  assign v_out      = v_q;
  assign IR_out     = ir_q;
  assign WD_out     = wd_q;
  assign stall      = (state_q == MEM_WAIT);
  assign mis_err    = mis_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU/jump results, loads, stores,
// misalignment, downstream backpressure and reset during an access.
module tb_mem_stage;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       IR_in, ALU_in, B_in, PC_in;
  logic              v_in, r_out, v_out, r_in;
  logic [31:0]       IR_out, WD_out, FM;
  logic [4:0]        AM;
  logic              stall, mis_err, dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  int errors = 0;
  int checks = 0;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .ALU_in(ALU_in), .B_in(B_in),
    .PC_in(PC_in), .v_in(v_in), .r_out(r_out), .v_out(v_out), .r_in(r_in),
    .IR_out(IR_out), .WD_out(WD_out), .FM(FM), .AM(AM), .stall(stall),
    .mis_err(mis_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory-op table: LHU, LH, LBU, LW to x0, SB, SW (ack on the first wait cycle).
  localparam logic [31:0] T_IR  [6] = '{32'h0000D383, 32'h00009383, 32'h0000C403,
                                        32'h0000A003, 32'h00308023, 32'h0030A023};
  localparam logic [31:0] T_ALU [6] = '{32'h102, 32'h102, 32'h101, 32'h104, 32'h301, 32'h300};
  localparam logic [31:0] T_B   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h123456A5, 32'hCAFEF00D};
  localparam logic [31:0] T_RD  [6] = '{32'h87654321, 32'h87654321, 32'h0000C300,
                                        32'hDEADBEEF, 32'h0, 32'h0};
  localparam logic [3:0]  T_BE  [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b0010, 4'hF};
  localparam logic [31:0] T_WDT [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'hCAFEF00D};
  localparam logic [31:0] T_WD  [6] = '{32'h00008765, 32'hFFFF8765, 32'h000000C3,
                                        32'hDEADBEEF, 32'h0, 32'h0};
  localparam logic [4:0]  T_AM  [6] = '{5'd7, 5'd7, 5'd8, 5'd0, 5'd0, 5'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_in = 1'b0; r_in = 1'b1; IR_in = '0; ALU_in = '0; B_in = '0; PC_in = '0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    step(); step();
    checks++;
    if ({v_out, dmem_req, dmem_we, stall, mis_err, dmem_be, AM, r_out} !== {5'b00000, 4'h0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b req=%b we=%b stall=%b mis=%b be=%h AM=%0d r_out=%b expected 0,0,0,0,0,0,0,1",
               v_out, dmem_req, dmem_we, stall, mis_err, dmem_be, AM, r_out);
    end
    checks++;
    if ({IR_out, WD_out, dmem_addr, dmem_wdata, FM} !== '0) begin
      errors++;
      $display("FAIL reset_data: got IR=%h WD=%h addr=%h wdata=%h FM=%h expected all 0",
               IR_out, WD_out, dmem_addr, dmem_wdata, FM);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({v_out, dmem_req, stall, r_out} !== 4'b0001) begin
      errors++;
      $display("FAIL stray_ack: got v=%b req=%b stall=%b r_out=%b expected 0001", v_out, dmem_req, stall, r_out);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_addi();
    IR_in = 32'h00500093; ALU_in = 32'h5; PC_in = 32'h10; v_in = 1'b1; r_in = 1'b1;
    #1;
    checks++;
    if (r_out !== 1'b1) begin
      errors++;
      $display("FAIL addi_ready: got r_out=%b expected 1", r_out);
    end
    step();
    v_in = 1'b0;
    checks++;
    if ({v_out, IR_out, WD_out, AM, FM, dmem_req} !== {1'b1, 32'h00500093, 32'h5, 5'd1, 32'h5, 1'b0}) begin
      errors++;
      $display("FAIL addi_result: got v=%b IR=%h WD=%h AM=%0d FM=%h req=%b expected 1 00500093 5 1 5 0",
               v_out, IR_out, WD_out, AM, FM, dmem_req);
    end
    step();
    checks++;
    if ({v_out, AM} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL addi_drain: got v=%b AM=%0d expected 0 0", v_out, AM);
    end
  endtask

  task automatic test_lb();
    IR_in = 32'h00008103; ALU_in = 32'h103; B_in = 32'hFFFFFFFF; v_in = 1'b1; r_in = 1'b1;
    step();
    v_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stall, r_out, dmem_req, dmem_we, dmem_be, v_out, dmem_addr} !== {4'b1010, 4'hF, 1'b0, 32'h100}) begin
        errors++;
        $display("FAIL lb_wait%0d: got stall=%b r_out=%b req=%b we=%b be=%h v=%b addr=%h expected 1 0 1 0 f 0 100",
                 i, stall, r_out, dmem_req, dmem_we, dmem_be, v_out, dmem_addr);
      end
      if (i == 2) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80000000;
      end
      step();
    end
    dmem_ack = 1'b0;
    checks++;
    if ({v_out, WD_out, AM, FM, stall, dmem_req} !== {1'b1, 32'hFFFFFF80, 5'd2, 32'hFFFFFF80, 2'b00}) begin
      errors++;
      $display("FAIL lb_result: got v=%b WD=%h AM=%0d FM=%h stall=%b req=%b expected 1 ffffff80 2 ffffff80 0 0",
               v_out, WD_out, AM, FM, stall, dmem_req);
    end
    step();
    checks++;
    if (v_out !== 1'b0) begin
      errors++;
      $display("FAIL lb_drain: got v=%b expected 0", v_out);
    end
  endtask

  task automatic test_sh_hold();
    IR_in = 32'h003093A3; ALU_in = 32'h202; B_in = 32'h1234ABCD; v_in = 1'b1; r_in = 1'b1;
    step();
    v_in = 1'b0;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {2'b11, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1}) begin
      errors++;
      $display("FAIL sh_req: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b expected 1 1 200 1100 abcdabcd 1",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall);
    end
    dmem_ack = 1'b1;
    r_in = 1'b0;
    step();
    dmem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v_out, AM, WD_out, dmem_req, stall, r_out, IR_out} !== {1'b1, 5'd0, 32'h0, 3'b000, 32'h003093A3}) begin
        errors++;
        $display("FAIL sh_hold%0d: got v=%b AM=%0d WD=%h req=%b stall=%b r_out=%b IR=%h expected 1 0 0 0 0 0 003093a3",
                 i, v_out, AM, WD_out, dmem_req, stall, r_out, IR_out);
      end
      step();
    end
    r_in = 1'b1;
    step();
    checks++;
    if ({v_out, r_out} !== 2'b01) begin
      errors++;
      $display("FAIL sh_release: got v=%b r_out=%b expected 0 1", v_out, r_out);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] irs [2];
    logic [31:0] alus [2];
    irs[0] = 32'h0000A283; alus[0] = 32'h105;  // LW x5
    irs[1] = 32'h00009483; alus[1] = 32'h103;  // LH x9
    for (int i = 0; i < 2; i++) begin
      IR_in = irs[i]; ALU_in = alus[i]; v_in = 1'b1; r_in = 1'b1;
      step();
      v_in = 1'b0;
      checks++;
      if ({dmem_req, mis_err, v_out, AM, WD_out, stall, IR_out} !== {3'b011, 5'd0, 32'h0, 1'b0, irs[i]}) begin
        errors++;
        $display("FAIL misalign%0d: got req=%b mis=%b v=%b AM=%0d WD=%h stall=%b IR=%h expected 0 1 1 0 0 0 %h",
                 i, dmem_req, mis_err, v_out, AM, WD_out, stall, IR_out, irs[i]);
      end
      step();
      checks++;
      if ({mis_err, v_out, dmem_req} !== 3'b000) begin
        errors++;
        $display("FAIL misalign_pulse%0d: got mis=%b v=%b req=%b expected 0 0 0", i, mis_err, v_out, dmem_req);
      end
    end
  endtask

  task automatic test_mem_table();
    for (int i = 0; i < 6; i++) begin
      IR_in = T_IR[i]; ALU_in = T_ALU[i]; B_in = T_B[i]; PC_in = 32'h80; v_in = 1'b1; r_in = 1'b1;
      step();
      v_in = 1'b0;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, mis_err, stall} !== {1'b1, (T_IR[i][6:0] == 7'b0100011), T_BE[i], 2'b01}) begin
        errors++;
        $display("FAIL table%0d_req: got req=%b we=%b be=%b mis=%b stall=%b expected be=%b", i,
                 dmem_req, dmem_we, dmem_be, mis_err, stall, T_BE[i]);
      end
      if (T_IR[i][6:0] == 7'b0100011) begin
        checks++;
        if (dmem_wdata !== T_WDT[i]) begin
          errors++;
          $display("FAIL table%0d_wdata: got %h expected %h", i, dmem_wdata, T_WDT[i]);
        end
      end
      dmem_ack = 1'b1;
      dmem_rdata = T_RD[i];
      step();
      dmem_ack = 1'b0;
      checks++;
      if ({v_out, WD_out, AM, FM, dmem_req} !== {1'b1, T_WD[i], T_AM[i], T_WD[i], 1'b0}) begin
        errors++;
        $display("FAIL table%0d_result: got v=%b WD=%h AM=%0d FM=%h req=%b expected 1 %h %0d %h 0",
                 i, v_out, WD_out, AM, FM, dmem_req, T_WD[i], T_AM[i], T_WD[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    IR_in = 32'h000000EF; PC_in = 32'h40; ALU_in = 32'h123; v_in = 1'b1; r_in = 1'b0;
    step();
    IR_in = 32'h00500093; ALU_in = 32'h5;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v_out, WD_out, IR_out, AM, r_out} !== {1'b1, 32'h44, 32'h000000EF, 5'd1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b WD=%h IR=%h AM=%0d r_out=%b expected 1 44 000000ef 1 0",
                 i, v_out, WD_out, IR_out, AM, r_out);
      end
      step();
    end
    v_in = 1'b0;
    r_in = 1'b1;
    #1;
    checks++;
    if (r_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: got r_out=%b expected 1", r_out);
    end
    step();
    checks++;
    if ({v_out, IR_out} !== {1'b0, 32'h000000EF}) begin
      errors++;
      $display("FAIL bp_transfer: got v=%b IR=%h expected 0 000000ef", v_out, IR_out);
    end
  endtask

  task automatic test_reset_mid();
    IR_in = 32'h0000A303; ALU_in = 32'h200; v_in = 1'b1; r_in = 1'b1;
    step();
    v_in = 1'b0;
    checks++;
    if ({dmem_req, stall} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_req: got req=%b stall=%b expected 1 1", dmem_req, stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_req, v_out, stall, r_out} !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b v=%b stall=%b r_out=%b expected 0 0 0 1", dmem_req, v_out, stall, r_out);
    end
    step();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0BAD0;
    step();
    dmem_ack = 1'b0;
    checks++;
    if ({v_out, dmem_req, WD_out, r_out} !== {2'b00, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_late_ack: got v=%b req=%b WD=%h r_out=%b expected 0 0 0 1", v_out, dmem_req, WD_out, r_out);
    end
    IR_in = 32'h0000A303; ALU_in = 32'h200; v_in = 1'b1;
    step();
    v_in = 1'b0;
    checks++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rstmid_retry_req: got req=%b addr=%h expected 1 200", dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11223344;
    step();
    dmem_ack = 1'b0;
    checks++;
    if ({v_out, WD_out, AM} !== {1'b1, 32'h11223344, 5'd6}) begin
      errors++;
      $display("FAIL rstmid_retry_result: got v=%b WD=%h AM=%0d expected 1 11223344 6", v_out, WD_out, AM);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lb();
    test_sh_hold();
    test_misaligned();
    test_mem_table();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4 (memory access) of the 5-stage RV32I core. Sits downstream of the execute stage and upstream of writeback.
- Consumes the execute stage's registered outputs (IR, ALU result, store data, PC) through the valid/ready handshake.
- Performs load/store accesses on a req/ack data-memory port and produces the writeback value.
- Drives the MEM forwarding pair (FM/AM) and the stall line back into execute.

Parameters:
- ADDR_W, 32, data-memory address width; upper bits of ALU_in are truncated to ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IR_in  in  32  instruction word from execute.
- ALU_in  in  32  ALU result: effective address for load/store, result otherwise.
- B_in  in  32  store data (rs2 value).
- PC_in  in  32  PC of the instruction.
- v_in  in  1  upstream valid.
- r_out  out  1  ready to upstream.
- v_out  out  1  downstream valid.
- r_in  in  1  downstream ready.
- IR_out  out  32  registered instruction word.
- WD_out  out  32  writeback data.
- FM  out  32  forwarded value; equals WD_out.
- AM  out  5  destination register of FM; 0 means nothing to forward.
- stall  out  1  freeze request to execute.
- mis_err  out  1  one-cycle pulse on a misaligned access.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address, low two bits 00.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read word, valid when dmem_ack=1.

Behaviour:
- Reset: async on rst_n=0. state=IDLE; v_out, dmem_req, dmem_we, stall and mis_err all 0; dmem_be=0; IR_out, WD_out, dmem_addr and dmem_wdata all 0; AM=0; r_out=1. Any dmem_ack during or after reset with no request outstanding is ignored.
- States: IDLE, MEM_WAIT, HOLD.
- Accept: on a clk edge with v_in & r_out.
- r_out = (state==IDLE) & (!v_out | r_in).
- Non-memory instruction (opcode not LOAD/STORE), accepted in IDLE, 1-cycle latency:
  - Next edge: v_out=1, IR_out=IR_in.
  - WD_out = PC_in+4 for JAL (1101111) and JALR (1100111); ALU_in otherwise.
- LOAD (0000011) or STORE (0100011), accepted and aligned:
  - Next edge: state=MEM_WAIT, dmem_req=1, dmem_we=STORE.
  - dmem_addr = {ALU_in[ADDR_W-1:2],2'b00}.
  - v_out drops to 0 unless HOLD data is still pending (HOLD cannot be active on accept, so v_out=0).
- Alignment rule:
  - funct3 010 needs addr[1:0]=00.
  - funct3 001 and 101 need addr[0]=0.
  - Byte accesses are always aligned.
- Misaligned access:
  - No memory request.
  - mis_err pulses for one cycle.
  - The instruction retires as a bubble: v_out=1, AM=0, WD_out=0.
- Store byte enables, with off=addr[1:0]:
  - SB: be=0001<<off; wdata = B_in[7:0] replicated into 4 lanes.
  - SH: be=0011<<off; wdata = B_in[15:0] replicated into 2 lanes.
  - SW: be=1111; wdata = B_in.
- Loads drive be=1111. Data is extracted from dmem_rdata at lane off:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: word unchanged.
  - Other funct3: WD_out=0.
- MEM_WAIT:
  - dmem_req, addr, be, wdata and we all held stable until dmem_ack.
  - stall=1 and r_out=0 for the whole state.
  - On the dmem_ack edge: dmem_req=0, WD_out loaded (load) or 0 (store), v_out=1, state=HOLD if !r_in else IDLE.
  - Minimum load latency is 2 edges from accept.
- HOLD: v_out, IR_out and WD_out held; r_out=0; stall=0. Exit to IDLE on an edge with r_in=1.
- Downstream backpressure in IDLE: when v_out & !r_in, all outputs hold and r_out=0.
- Forwarding: AM = IR_out[11:7] when v_out=1 and the opcode is not STORE/BRANCH and the instruction was not misaligned; otherwise AM=0. AM is also 0 when rd=x0.
- An instruction with v_in=0 is never accepted, and a flush bubble leaves no state.
- Reset asserted during MEM_WAIT drops dmem_req immediately and abandons the access. The memory must tolerate the withdrawn request.

Test Plan:
- ADDI result: IR=0x00500093, ALU_in=5, r_in=1 -> next edge v_out=1, WD_out=5, AM=1, FM=5, no dmem_req.
- LB sign-extend: ALU_in=0x103, dmem_rdata=0x80_00_00_00, ack 3 cycles after req -> dmem_addr=0x100, be=1111, stall=1 for 3 cycles, then WD_out=0xFFFFFF80, v_out=1.
- SH: ALU_in=0x202, B_in=0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1; after ack v_out=1, AM=0.
- Misaligned LW: ALU_in=0x105 -> no dmem_req, mis_err one pulse, v_out=1, AM=0.
- Backpressure: JAL at PC=0x40 with r_in=0 for 2 cycles -> WD_out=0x44 held, r_out=0; one transfer when r_in rises.
- Reset mid-access: rst_n=0 during MEM_WAIT -> dmem_req=0 asynchronously, v_out=0; a late ack is ignored and the next LW completes normally.
